// File: rtl/apmon_pkg.sv
// Shared types and constants for the ap_ctrl performance monitor.
package apmon_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BUSY      = 2'd1,
        DONE_WAIT = 2'd2
    } apmon_state_e;

    // Statistic selectors for rd_field
    localparam logic [2:0] F_TXN      = 3'd0;
    localparam logic [2:0] F_BUSY     = 3'd1;
    localparam logic [2:0] F_STALL    = 3'd2;
    localparam logic [2:0] F_READY    = 3'd3;
    localparam logic [2:0] F_LAT_MIN  = 3'd4;
    localparam logic [2:0] F_LAT_MAX  = 3'd5;
    localparam logic [2:0] F_LAT_LAST = 3'd6;
    localparam logic [2:0] F_STATUS   = 3'd7;

    // Per-channel ch_mode encoding
    localparam logic MODE_FULL       = 1'b0;
    localparam logic MODE_READY_ONLY = 1'b1;

endpackage

// File: rtl/ap_ctrl_ch_monitor.sv
// One monitored channel: ap_ctrl handshake FSM plus its saturating statistics.
module ap_ctrl_ch_monitor
    import apmon_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             frozen,
    input  logic             mode,
    input  logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    input  logic             ap_continue,
    output logic [1:0]       state,
    output logic             overflow,
    output logic [CNT_W-1:0] txn,
    output logic [CNT_W-1:0] busy,
    output logic [CNT_W-1:0] stall,
    output logic [CNT_W-1:0] ready_cnt,
    output logic [CNT_W-1:0] lat_min,
    output logic [CNT_W-1:0] lat_max,
    output logic [CNT_W-1:0] lat_last
);
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CntMax = '1;

    apmon_state_e     state_q, state_d;
    logic [CNT_W-1:0] lat_run_q, lat_run_d, lat_run_inc, lat_val;
    logic             txn_ev, busy_ev, stall_ev, lat_ev, run_sat, wrap;
    logic [CNT_W-1:0] txn_q, busy_q, stall_q, ready_q, lat_min_q, lat_max_q, lat_last_q;
    logic             ovf_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CntMax) ? v : v + CntOne;
    endfunction

    // FSM state and running latency; these keep tracking through clear and freeze
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            lat_run_q <= '0;
        end else begin
            state_q   <= state_d;
            lat_run_q <= lat_run_d;
        end
    end

    // Next-state logic; READY_ONLY mode pins the channel to IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (ap_start) begin
                state_d = ap_done ? (ap_continue ? IDLE : DONE_WAIT) : BUSY;
            end
            BUSY: if (ap_done) begin
                state_d = !ap_continue ? DONE_WAIT : (ap_start ? BUSY : IDLE);
            end
            DONE_WAIT: if (ap_continue) begin
                state_d = ap_start ? BUSY : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (mode == MODE_READY_ONLY) state_d = IDLE;
    end

    // Per-cycle statistic events and running-latency update
    always_comb begin
        txn_ev      = 1'b0;
        busy_ev     = 1'b0;
        stall_ev    = 1'b0;
        lat_ev      = 1'b0;
        run_sat     = 1'b0;
        lat_run_inc = sat_inc(lat_run_q);
        lat_val     = lat_run_inc;
        lat_run_d   = lat_run_q;
        if (mode == MODE_FULL) begin
            unique case (state_q)
                IDLE: if (ap_start) begin
                    busy_ev   = 1'b1;
                    lat_run_d = CntOne;
                    if (ap_done) begin
                        txn_ev  = 1'b1;
                        lat_ev  = 1'b1;
                        lat_val = CntOne;
                    end
                end
                BUSY: begin
                    busy_ev   = 1'b1;
                    run_sat   = (lat_run_q == CntMax);
                    lat_run_d = lat_run_inc;
                    if (ap_done) begin
                        txn_ev = 1'b1;
                        lat_ev = 1'b1;
                        // Back-to-back: the done cycle is cycle 1 of the next transaction
                        if (ap_continue && ap_start) lat_run_d = CntOne;
                    end
                end
                DONE_WAIT: begin
                    stall_ev = 1'b1;
                    if (ap_continue && ap_start) lat_run_d = CntOne;
                end
                default: ;
            endcase
        end
    end

    assign wrap = (txn_ev && txn_q == CntMax) || (busy_ev && busy_q == CntMax) ||
                  (stall_ev && stall_q == CntMax) || (ap_ready && ready_q == CntMax) || run_sat;

    // Statistics: reset > clear > frozen > update
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            txn_q      <= '0;
            busy_q     <= '0;
            stall_q    <= '0;
            ready_q    <= '0;
            lat_min_q  <= CntMax;
            lat_max_q  <= '0;
            lat_last_q <= '0;
            ovf_q      <= 1'b0;
        end else if (!frozen) begin
            if (txn_ev)   txn_q   <= sat_inc(txn_q);
            if (busy_ev)  busy_q  <= sat_inc(busy_q);
            if (stall_ev) stall_q <= sat_inc(stall_q);
            if (ap_ready) ready_q <= sat_inc(ready_q);
            if (lat_ev) begin
                lat_last_q <= lat_val;
                if (lat_val < lat_min_q) lat_min_q <= lat_val;
                if (lat_val > lat_max_q) lat_max_q <= lat_val;
            end
            if (wrap) ovf_q <= 1'b1;
        end
    end

    assign state     = state_q;
    assign overflow  = ovf_q;
    assign txn       = txn_q;
    assign busy      = busy_q;
    assign stall     = stall_q;
    assign ready_cnt = ready_q;
    assign lat_min   = lat_min_q;
    assign lat_max   = lat_max_q;
    assign lat_last  = lat_last_q;

endmodule

// File: rtl/ap_ctrl_perf_monitor.sv
// N-channel ap_ctrl performance monitor with registered statistic read port.
module ap_ctrl_perf_monitor
    import apmon_pkg::*;
#(
    parameter int unsigned NUM_CH = 6,
    parameter int unsigned CNT_W  = 32,
    // Derived; leave at default
    parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              finish,
    input  logic [NUM_CH-1:0] ch_mode,
    input  logic [NUM_CH-1:0] ap_start,
    input  logic [NUM_CH-1:0] ap_ready,
    input  logic [NUM_CH-1:0] ap_done,
    input  logic [NUM_CH-1:0] ap_continue,
    input  logic              rd_en,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic [2:0]        rd_field,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  rd_data,
    output logic              any_busy,
    output logic              frozen,
    output logic [NUM_CH-1:0] overflow
);
    logic [1:0]       st       [NUM_CH];
    logic [CNT_W-1:0] txn      [NUM_CH];
    logic [CNT_W-1:0] busy     [NUM_CH];
    logic [CNT_W-1:0] stall    [NUM_CH];
    logic [CNT_W-1:0] ready    [NUM_CH];
    logic [CNT_W-1:0] lat_min  [NUM_CH];
    logic [CNT_W-1:0] lat_max  [NUM_CH];
    logic [CNT_W-1:0] lat_last [NUM_CH];
    logic [NUM_CH-1:0] busy_vec;
    logic [CNT_W-1:0]  rd_mux;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        ap_ctrl_ch_monitor #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clock      (clock),
            .reset      (reset),
            .clear      (clear),
            .frozen     (frozen),
            .mode       (ch_mode[g]),
            .ap_start   (ap_start[g]),
            .ap_ready   (ap_ready[g]),
            .ap_done    (ap_done[g]),
            .ap_continue(ap_continue[g]),
            .state      (st[g]),
            .overflow   (overflow[g]),
            .txn        (txn[g]),
            .busy       (busy[g]),
            .stall      (stall[g]),
            .ready_cnt  (ready[g]),
            .lat_min    (lat_min[g]),
            .lat_max    (lat_max[g]),
            .lat_last   (lat_last[g])
        );
        assign busy_vec[g] = (st[g] != IDLE);
    end

    assign any_busy = |busy_vec;

    // Read mux; channels beyond NUM_CH fall through to zero
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch == CH_W'(i)) begin
                case (rd_field)
                    F_TXN:      rd_mux = txn[i];
                    F_BUSY:     rd_mux = busy[i];
                    F_STALL:    rd_mux = stall[i];
                    F_READY:    rd_mux = ready[i];
                    F_LAT_MIN:  rd_mux = lat_min[i];
                    F_LAT_MAX:  rd_mux = lat_max[i];
                    F_LAT_LAST: rd_mux = lat_last[i];
                    F_STATUS:   rd_mux = {{(CNT_W-4){1'b0}}, ch_mode[i], overflow[i], st[i]};
                    default:    rd_mux = '0;
                endcase
            end
        end
    end

    // Registered read response; samples pre-update statistics
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= rd_mux;
        end
    end

    // Sticky end-of-run freeze, released only by reset
    always_ff @(posedge clock) begin
        if (reset) frozen <= 1'b0;
        else if (finish) frozen <= 1'b1;
    end

endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
// Self-checking bench for ap_ctrl_perf_monitor (6 channels, 8-bit counters).
module tb_ap_ctrl_perf_monitor;
    import apmon_pkg::*;

    localparam int unsigned NUM_CH = 6;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned CH_W   = 3;

    logic              clock = 1'b0;
    logic              reset, clear, finish;
    logic [NUM_CH-1:0] ch_mode, ap_start, ap_ready, ap_done, ap_continue;
    logic              rd_en;
    logic [CH_W-1:0]   rd_ch;
    logic [2:0]        rd_field;
    logic              rd_valid;
    logic [CNT_W-1:0]  rd_data;
    logic              any_busy, frozen;
    logic [NUM_CH-1:0] overflow;

    typedef struct {
        int               step;
        int unsigned      ch;
        logic [2:0]       field;
        logic [CNT_W-1:0] want;
        string            name;
    } rd_vec_t;

    typedef struct {
        logic [CNT_W-1:0] want;
        string            name;
    } sb_t;

    rd_vec_t vecs[$];
    sb_t     sb_q[$];
    int      checks = 0;
    int      errors = 0;

    ap_ctrl_perf_monitor #(
        .NUM_CH(NUM_CH),
        .CNT_W (CNT_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear),
        .finish     (finish),
        .ch_mode    (ch_mode),
        .ap_start   (ap_start),
        .ap_ready   (ap_ready),
        .ap_done    (ap_done),
        .ap_continue(ap_continue),
        .rd_en      (rd_en),
        .rd_ch      (rd_ch),
        .rd_field   (rd_field),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .any_busy   (any_busy),
        .frozen     (frozen),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    // Inputs change and outputs are sampled just after the falling edge
    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, want);
        end
    endtask

    // Issue a one-cycle read, queue its expectation, and score it when rd_valid appears
    task automatic rd(input int unsigned ch, input logic [2:0] field,
                      input logic [CNT_W-1:0] want, input string name);
        logic [31:0] chv;
        sb_t         e;
        chv      = ch;
        rd_en    = 1'b1;
        rd_ch    = chv[CH_W-1:0];
        rd_field = field;
        sb_q.push_back('{want: want, name: name});
        cyc(1);
        rd_en = 1'b0;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb_q.pop_front();
            if (!rd_valid) begin
                errors++;
                $display("FAIL %s: rd_valid=0, expected 1 with data %0d", e.name, e.want);
            end else if (rd_data !== e.want) begin
                errors++;
                $display("FAIL %s: rd_data=%0d expected %0d", e.name, rd_data, e.want);
            end
        end
    endtask

    function automatic void add(input int step, input int unsigned ch, input logic [2:0] field,
                                input logic [CNT_W-1:0] want, input string name);
        vecs.push_back('{step: step, ch: ch, field: field, want: want, name: name});
    endfunction

    task automatic apply(input int step);
        foreach (vecs[i]) begin
            if (vecs[i].step == step) rd(vecs[i].ch, vecs[i].field, vecs[i].want, vecs[i].name);
        end
    endtask

    initial begin
        // Expected statistics per scenario
        add(0, 0, F_TXN,      8'd0,   "rst_txn");
        add(0, 0, F_BUSY,     8'd0,   "rst_busy");
        add(0, 0, F_STALL,    8'd0,   "rst_stall");
        add(0, 0, F_READY,    8'd0,   "rst_ready");
        add(0, 0, F_LAT_MIN,  8'd255, "rst_lat_min");
        add(0, 0, F_LAT_MAX,  8'd0,   "rst_lat_max");
        add(0, 0, F_LAT_LAST, 8'd0,   "rst_lat_last");
        add(0, 5, F_STATUS,   8'd0,   "rst_status");
        add(1, 0, F_TXN,      8'd1,   "t1_txn");
        add(1, 0, F_BUSY,     8'd5,   "t1_busy");
        add(1, 0, F_STALL,    8'd0,   "t1_stall");
        add(1, 0, F_LAT_LAST, 8'd5,   "t1_lat_last");
        add(1, 0, F_LAT_MIN,  8'd5,   "t1_lat_min");
        add(1, 0, F_LAT_MAX,  8'd5,   "t1_lat_max");
        add(1, 0, F_STATUS,   8'd0,   "t1_status");
        add(2, 1, F_STALL,    8'd3,   "t2_stall");
        add(2, 1, F_TXN,      8'd1,   "t2_txn");
        add(2, 1, F_BUSY,     8'd2,   "t2_busy");
        add(2, 1, F_LAT_LAST, 8'd2,   "t2_lat_last");
        add(2, 1, F_STATUS,   8'd0,   "t2_status_idle");
        add(3, 2, F_TXN,      8'd3,   "t3_txn");
        add(3, 2, F_LAT_MIN,  8'd2,   "t3_lat_min");
        add(3, 2, F_LAT_MAX,  8'd7,   "t3_lat_max");
        add(3, 2, F_LAT_LAST, 8'd3,   "t3_lat_last");
        add(3, 2, F_BUSY,     8'd10,  "t3_busy");
        add(4, 3, F_TXN,      8'd1,   "t4_txn");
        add(4, 3, F_LAT_MIN,  8'd1,   "t4_lat_min");
        add(4, 3, F_LAT_MAX,  8'd1,   "t4_lat_max");
        add(4, 3, F_LAT_LAST, 8'd1,   "t4_lat_last");
        add(4, 3, F_STATUS,   8'd0,   "t4_status");
        add(5, 4, F_READY,    8'd255, "t5_ready_sat");
        add(5, 4, F_TXN,      8'd0,   "t5_txn");
        add(5, 4, F_BUSY,     8'd0,   "t5_busy");
        add(5, 4, F_STATUS,   8'd12,  "t5_status");
        add(6, 4, F_READY,    8'd0,   "t5c_ready");
        add(6, 4, F_LAT_MIN,  8'd255, "t5c_lat_min");
        add(6, 4, F_STATUS,   8'd8,   "t5c_status");
        add(6, 0, F_TXN,      8'd0,   "t5c_ch0_txn");
        add(6, 2, F_LAT_MAX,  8'd0,   "t5c_ch2_lat_max");
        add(7, 5, F_TXN,      8'd0,   "t6_txn_frozen");
        add(7, 5, F_BUSY,     8'd2,   "t6_busy_frozen");
        add(7, 5, F_LAT_LAST, 8'd0,   "t6_lat_last");
        add(7, 5, F_STATUS,   8'd0,   "t6_status_idle");
        add(7, 6, F_TXN,      8'd0,   "t6_rd_ch6");
        add(7, 7, F_STATUS,   8'd0,   "t6_rd_ch7");

        reset = 1'b1; clear = 1'b0; finish = 1'b0;
        ch_mode = '0; ap_start = '0; ap_ready = '0; ap_done = '0; ap_continue = '1;
        rd_en = 1'b0; rd_ch = '0; rd_field = '0;
        cyc(3);
        reset = 1'b0;

        chk("rst_any_busy", any_busy, 0);
        chk("rst_frozen", frozen, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        apply(0);
        cyc(1);
        chk("rd_valid_drop", rd_valid, 0);

        // 1: start at t, done at t+4
        ap_start[0] = 1'b1; cyc(1);
        ap_start[0] = 1'b0;
        chk("t1_any_busy", any_busy, 1);
        cyc(3);
        ap_done[0] = 1'b1; cyc(1);
        ap_done[0] = 1'b0;
        apply(1);

        // 2: done with continue low on the done cycle and the two after
        ap_start[1] = 1'b1; cyc(1);
        ap_start[1] = 1'b0; ap_done[1] = 1'b1; ap_continue[1] = 1'b0; cyc(1);
        ap_done[1] = 1'b0;
        rd(1, F_STATUS, 8'd2, "t2_status_done_wait");
        cyc(1);
        ap_continue[1] = 1'b1;
        chk("t2_any_busy_wait", any_busy, 1);
        cyc(1);
        chk("t2_any_busy_fall", any_busy, 0);
        apply(2);

        // 3: start held, done at latencies 2, 7, 3
        ap_start[2] = 1'b1; cyc(1);
        ap_done[2] = 1'b1; cyc(1);
        ap_done[2] = 1'b0; cyc(5);
        ap_done[2] = 1'b1; cyc(1);
        ap_done[2] = 1'b0; cyc(1);
        ap_done[2] = 1'b1; ap_start[2] = 1'b0; cyc(1);
        ap_done[2] = 1'b0;
        apply(3);

        // 4: start and done together from IDLE
        ap_start[3] = 1'b1; ap_done[3] = 1'b1; cyc(1);
        ap_start[3] = 1'b0; ap_done[3] = 1'b0;
        chk("t4_any_busy", any_busy, 0);
        apply(4);

        // 5: READY_ONLY saturation, then clear
        ch_mode[4] = 1'b1; ap_ready[4] = 1'b1; ap_start[4] = 1'b1;
        cyc(300);
        ap_ready[4] = 1'b0; ap_start[4] = 1'b0;
        chk("t5_overflow", overflow, 6'b010000);
        chk("t5_any_busy", any_busy, 0);
        apply(5);
        clear = 1'b1;
        rd(4, F_READY, 8'd255, "t5_rd_during_clear");
        clear = 1'b0;
        chk("t5c_overflow", overflow, 0);
        apply(6);
        ch_mode[4] = 1'b0;

        // 6: finish mid-transaction
        ap_start[5] = 1'b1; cyc(1);
        ap_start[5] = 1'b0; finish = 1'b1;
        chk("t6_frozen_before", frozen, 0);
        cyc(1);
        finish = 1'b0;
        chk("t6_frozen_set", frozen, 1);
        ap_done[5] = 1'b1; cyc(1);
        ap_start[5] = 1'b1; cyc(1);
        ap_start[5] = 1'b0; ap_done[5] = 1'b0;
        chk("t6_any_busy", any_busy, 0);
        apply(7);
        reset = 1'b1; cyc(1);
        reset = 1'b0;
        chk("t6_frozen_reset", frozen, 0);
        rd(5, F_BUSY, 8'd0, "t6_busy_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
